// File: rtl/approx_pkg.sv
// Shared types for the approximate-multiplier error monitor.
// FSM encoding and default operand width.
package approx_pkg;

  localparam int unsigned APPROX_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  function automatic logic stat_clear(
    input state_e s,
    input logic   start
  );
    return start && ((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/approx_err_monitor_abs_diff.sv
// abs_diff: combinational unsigned distance |a - b|.
// Reusable by any metric block that needs an error distance.
module abs_diff #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] d_o
);

  assign d_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/approx_err_monitor.sv
// approx_err_monitor: batch error statistics for an approximate multiplier.
// Define APPROX_ERR_SQ_EN to add sum_sq_ed (sum of squared error distance).
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter int unsigned WIDTH       = APPROX_WIDTH,
  parameter int unsigned NUM_SAMPLES = 256,
  parameter int unsigned CNT_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         x,
  input  logic [WIDTH-1:0]         y,
  input  logic [2*WIDTH-1:0]       p,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_W-1:0]         sample_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [2*WIDTH+CNT_W-1:0] sum_ed,
  output logic [2*WIDTH-1:0]       max_ed,
  output logic [WIDTH-1:0]         max_x,
`ifdef APPROX_ERR_SQ_EN
  output logic [WIDTH-1:0]         max_y,
  output logic [4*WIDTH+CNT_W-1:0] sum_sq_ed
`else
  output logic [WIDTH-1:0]         max_y
`endif
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned SW = PW + CNT_W;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(NUM_SAMPLES - 1);

  state_e           state_q;
  logic             rdy_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;

  logic acc;
  logic clr;
  logic pipe_busy;

  logic             s1_v_q;
  logic [WIDTH-1:0] s1_x_q;
  logic [WIDTH-1:0] s1_y_q;
  logic [PW-1:0]    s1_p_q;
  logic [PW-1:0]    s1_exact_q;
  logic [PW-1:0]    exact_d;

  logic             s2_v_q;
  logic [WIDTH-1:0] s2_x_q;
  logic [WIDTH-1:0] s2_y_q;
  logic [PW-1:0]    s2_ed_q;
  logic [PW-1:0]    ed_d;

  logic [CNT_W-1:0] err_q;
  logic [SW-1:0]    sum_q;
  logic [PW-1:0]    max_q;
  logic [WIDTH-1:0] mx_q;
  logic [WIDTH-1:0] my_q;

  assign acc     = in_valid && rdy_q;
  assign clr     = stat_clear(state_q, start);
  assign exact_d = PW'(x) * PW'(y);

`ifdef APPROX_ERR_SQ_EN
  localparam int unsigned QW = 4 * WIDTH;
  localparam int unsigned SQW = QW + CNT_W;

  logic           s3_v_q;
  logic [QW-1:0]  s3_sq_q;
  logic [SQW-1:0] sum_sq_q;

  assign pipe_busy = s1_v_q || s2_v_q || s3_v_q;
`else
  assign pipe_busy = s1_v_q || s2_v_q;
`endif

  // Control FSM; outputs are registered with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q <= ST_RUN;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
          end
        end
        ST_RUN: begin
          if (acc) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
              state_q <= ST_DRAIN;
              rdy_q   <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (!pipe_busy) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_p_q     <= '0;
      s1_exact_q <= '0;
    end else begin
      s1_v_q <= acc && !clr;
      if (acc) begin
        s1_x_q     <= x;
        s1_y_q     <= y;
        s1_p_q     <= p;
        s1_exact_q <= exact_d;
      end
    end
  end

  abs_diff #(.W(PW)) u_abs_diff (
    .a_i (s1_exact_q),
    .b_i (s1_p_q),
    .d_o (ed_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q  <= 1'b0;
      s2_x_q  <= '0;
      s2_y_q  <= '0;
      s2_ed_q <= '0;
    end else begin
      s2_v_q <= s1_v_q && !clr;
      if (s1_v_q) begin
        s2_x_q  <= s1_x_q;
        s2_y_q  <= s1_y_q;
        s2_ed_q <= ed_d;
      end
    end
  end

  // Strictly-greater compare keeps the first sample on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
      mx_q  <= '0;
      my_q  <= '0;
    end else if (clr) begin
      err_q <= '0;
      sum_q <= '0;
      max_q <= '0;
      mx_q  <= '0;
      my_q  <= '0;
    end else if (s2_v_q) begin
      if (s2_ed_q != '0) begin
        err_q <= err_q + CNT_W'(1);
      end
      sum_q <= sum_q + SW'(s2_ed_q);
      if (s2_ed_q > max_q) begin
        max_q <= s2_ed_q;
        mx_q  <= s2_x_q;
        my_q  <= s2_y_q;
      end
    end
  end

`ifdef APPROX_ERR_SQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_v_q   <= 1'b0;
      s3_sq_q  <= '0;
      sum_sq_q <= '0;
    end else begin
      s3_v_q <= s2_v_q && !clr;
      if (s2_v_q) begin
        s3_sq_q <= QW'(s2_ed_q) * QW'(s2_ed_q);
      end
      if (clr) begin
        sum_sq_q <= '0;
      end else if (s3_v_q) begin
        sum_sq_q <= sum_sq_q + SQW'(s3_sq_q);
      end
    end
  end

  assign sum_sq_ed = sum_sq_q;
`endif

  assign in_ready   = rdy_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sample_cnt = cnt_q;
  assign err_cnt    = err_q;
  assign sum_ed     = sum_q;
  assign max_ed     = max_q;
  assign max_x      = mx_q;
  assign max_y      = my_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Bench for approx_err_monitor: directed batches, random batches,
// backpressure gaps, ignored start, mid-batch reset.
module tb_approx_err_monitor;

  localparam int NS = 4;
  localparam int W  = 8;
  localparam int CW = $clog2(NS + 1);
  localparam int PW = 2 * W;
  localparam int SW = PW + CW;
`ifdef APPROX_ERR_SQ_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  x = '0;
  logic [W-1:0]  y = '0;
  logic [PW-1:0] p = '0;
  logic          busy;
  logic          done;
  logic [CW-1:0] sample_cnt;
  logic [CW-1:0] err_cnt;
  logic [SW-1:0] sum_ed;
  logic [PW-1:0] max_ed;
  logic [W-1:0]  max_x;
  logic [W-1:0]  max_y;
`ifdef APPROX_ERR_SQ_EN
  logic [4*W+CW-1:0] sum_sq_ed;
`endif

  approx_err_monitor #(
    .WIDTH       (W),
    .NUM_SAMPLES (NS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .y          (y),
    .p          (p),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .sum_ed     (sum_ed),
    .max_ed     (max_ed),
    .max_x      (max_x),
`ifdef APPROX_ERR_SQ_EN
    .max_y      (max_y),
    .sum_sq_ed  (sum_sq_ed)
`else
    .max_y      (max_y)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int xs[NS];
  int ys[NS];
  int ps[NS];

  int     m_err;
  int     m_sum;
  int     m_max;
  int     m_mx;
  int     m_my;
  longint m_sq;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference statistics straight from the definition of the metrics.
  task automatic model();
    int e;
    m_err = 0; m_sum = 0; m_max = 0;
    m_mx = 0; m_my = 0; m_sq = 0;
    for (int i = 0; i < NS; i++) begin
      e = xs[i] * ys[i] - ps[i];
      if (e < 0) e = -e;
      if (e != 0) m_err++;
      m_sum += e;
      m_sq += longint'(e) * longint'(e);
      if (e > m_max) begin
        m_max = e; m_mx = xs[i]; m_my = ys[i];
      end
    end
  endtask

  task automatic rand_fill();
    int ex;
    int pv;
    for (int i = 0; i < NS; i++) begin
      xs[i] = int'($urandom_range(0, 255));
      ys[i] = int'($urandom_range(0, 255));
      ex = xs[i] * ys[i];
      case ($urandom_range(0, 3))
        0: pv = ex;
        1: pv = ex + int'($urandom_range(0, 3));
        2: pv = ex - int'($urandom_range(0, 3));
        default: pv = int'($urandom_range(0, 65535));
      endcase
      if (pv < 0) pv = 0;
      if (pv > 65535) pv = 65535;
      ps[i] = pv;
    end
  endtask

  task automatic chk_zero_stats(input string tag);
    chk({tag, "_cnt"}, 64'(sample_cnt), 0);
    chk({tag, "_err"}, 64'(err_cnt), 0);
    chk({tag, "_sum"}, 64'(sum_ed), 0);
    chk({tag, "_max"}, 64'(max_ed), 0);
    chk({tag, "_mx"}, 64'(max_x), 0);
    chk({tag, "_my"}, 64'(max_y), 0);
`ifdef APPROX_ERR_SQ_EN
    chk({tag, "_sq"}, 64'(sum_sq_ed), 0);
`endif
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_zero_stats("start");
    chk("start_busy", 64'(busy), 1);
    chk("start_done", 64'(done), 0);
    chk("start_rdy", 64'(in_ready), 1);
  endtask

  // gmode: 0 back-to-back, 1 alternating gaps, 2 random gaps.
  task automatic feed(input int gmode, input bit poke, input int n);
    int  accd = 0;
    int  ph = 0;
    bit  gap;
    while (accd < n) begin
      gap = (gmode == 1) ? ph[0] :
            (gmode == 2) ? bit'($urandom_range(0, 1)) : 1'b0;
      if (gap) begin
        in_valid = 1'b0;
        x = W'($urandom);
        start = poke;
      end else begin
        in_valid = 1'b1;
        x = W'(xs[accd]);
        y = W'(ys[accd]);
        p = PW'(ps[accd]);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (in_valid) accd++;
      if (gmode != 0) chk("hs_cnt", 64'(sample_cnt), 64'(accd));
      ph++;
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_batch(input string tag);
    int k = 0;
    chk({tag, "_rdy_off"}, 64'(in_ready), 0);
    do begin
      @(posedge clk); #1;
      k++;
    end while (!done && k < 20);
    chk({tag, "_latency"}, 64'(k), 64'(LAT));
    model();
    chk({tag, "_cnt"}, 64'(sample_cnt), 64'(NS));
    chk({tag, "_err"}, 64'(err_cnt), 64'(m_err));
    chk({tag, "_sum"}, 64'(sum_ed), 64'(m_sum));
    chk({tag, "_max"}, 64'(max_ed), 64'(m_max));
    chk({tag, "_mx"}, 64'(max_x), 64'(m_mx));
    chk({tag, "_my"}, 64'(max_y), 64'(m_my));
`ifdef APPROX_ERR_SQ_EN
    chk({tag, "_sq"}, 64'(sum_sq_ed), 64'(m_sq));
`endif
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk_zero_stats(tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_rdy"}, 64'(in_ready), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_reset_state("idle_valid");

    xs = '{1, 4, 255, 0};
    ys = '{2, 5, 255, 7};
    ps = '{2, 20, 65025, 0};
    do_start();
    feed(0, 1'b0, NS);
    finish_batch("exact");

    xs = '{4, 3, 10, 2};
    ys = '{5, 3, 10, 2};
    ps = '{18, 12, 97, 4};
    do_start();
    feed(1, 1'b1, NS);
    finish_batch("errs");
    chk("errs_const_sum", 64'(sum_ed), 8);
    chk("errs_const_mx", 64'(max_x), 3);

    for (int b = 0; b < 6; b++) begin
      rand_fill();
      do_start();
      feed(b % 3, b[0], NS);
      finish_batch("rand");
    end

    rand_fill();
    do_start();
    feed(0, 1'b0, 2);
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    #3 rst_n = 1'b1;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk_reset_state("post_rst");

    rand_fill();
    do_start();
    feed(2, 1'b0, NS);
    finish_batch("after_rst");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
